// File: rtl/ctrl_pipe_if.sv
// Handshake/bus bundle for ctrl_pipe; the performance counter signals exist
// only when CTRL_PIPE_PERF_EN is defined.
interface ctrl_pipe_if #(
    parameter int W = 14,
    parameter int N = 3
);
    logic               in_valid;
    logic [W-1:0]       in_ctrl;
    logic               in_ready;
    logic [N-1:0]       stall_req;
    logic [N-1:0]       flush_req;
    logic               out_ready;
    logic [N-1:0]       stage_valid;
    logic [N*W-1:0]     stage_ctrl;
    logic [N-1:0]       held;
    logic               out_valid;
    logic [W-1:0]       out_ctrl;
`ifdef CTRL_PIPE_PERF_EN
    logic               perf_clr;
    logic [31:0]        stall_cycles;
    logic [31:0]        bubble_cycles;

    modport master (
        output in_valid, in_ctrl, stall_req, flush_req, out_ready, perf_clr,
        input  in_ready, stage_valid, stage_ctrl, held, out_valid, out_ctrl,
               stall_cycles, bubble_cycles
    );
    modport slave (
        input  in_valid, in_ctrl, stall_req, flush_req, out_ready, perf_clr,
        output in_ready, stage_valid, stage_ctrl, held, out_valid, out_ctrl,
               stall_cycles, bubble_cycles
    );
`else
    modport master (
        output in_valid, in_ctrl, stall_req, flush_req, out_ready,
        input  in_ready, stage_valid, stage_ctrl, held, out_valid, out_ctrl
    );
    modport slave (
        input  in_valid, in_ctrl, stall_req, flush_req, out_ready,
        output in_ready, stage_valid, stage_ctrl, held, out_valid, out_ctrl
    );
`endif
endinterface

// File: rtl/ctrl_pipe.sv
// N-stage control pipeline with per-stage stall/flush and bubble squeezing.
// Optional cycle counters are built only when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe #(
    parameter int W = 14,
    parameter int N = 3
) (
    input  logic        clk,
    input  logic        rst,
    ctrl_pipe_if.slave  bus
);
    logic [N-1:0]         r_valid;
    logic [N-1:0][W-1:0]  r_ctrl;
    logic [N-1:0]         w_held;
    logic [N-1:0]         w_valid_nxt;
    logic [N-1:0][W-1:0]  w_ctrl_nxt;

    // A stage is held by downstream only while it actually carries a bundle,
    // so bubbles are squeezed out instead of propagating the hold upstream.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_held = bus.stall_req;
        w_held[N-1] = bus.stall_req[N-1] | (r_valid[N-1] & ~bus.out_ready);
        for (int k = N - 2; k >= 0; k--) begin
            w_held[k] = bus.stall_req[k] | (r_valid[k] & w_held[k+1]);
        end
    end

    always_comb begin
        w_valid_nxt = r_valid;
        w_ctrl_nxt  = r_ctrl;
        if (!w_held[0]) begin
            w_valid_nxt[0] = bus.in_valid;
            w_ctrl_nxt[0]  = bus.in_ctrl;
        end
        for (int k = 1; k < N; k++) begin
            if (!w_held[k]) begin
                w_valid_nxt[k] = w_held[k-1] ? 1'b0 : r_valid[k-1];
                w_ctrl_nxt[k]  = r_ctrl[k-1];
            end
        end
        // Flush overrides both hold and load; bubbles always carry zero control.
        for (int k = 0; k < N; k++) begin
            if (bus.flush_req[k]) begin
                w_valid_nxt[k] = 1'b0;
            end
            if (!w_valid_nxt[k]) begin
                w_ctrl_nxt[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // stage samples its neighbour's pre-edge value.
            r_valid <= '0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_ctrl  <= w_ctrl_nxt;
        end
    end

    assign bus.in_ready    = ~w_held[0];
    assign bus.held        = w_held;
    assign bus.stage_valid = r_valid;
    assign bus.stage_ctrl  = r_ctrl;
    assign bus.out_valid   = r_valid[N-1];
    assign bus.out_ctrl    = r_ctrl[N-1];

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
        end else if (bus.perf_clr) begin
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
        end else begin
            if (bus.in_valid && w_held[0] && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (!r_valid[N-1] && (r_bubble_cycles != 32'hFFFF_FFFF)) begin
                r_bubble_cycles <= r_bubble_cycles + 32'd1;
            end
        end
    end

    assign bus.stall_cycles  = r_stall_cycles;
    assign bus.bubble_cycles = r_bubble_cycles;
`endif
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe (W=14, N=3); a negedge monitor checks the output
// stream against a queue of expected bundles filled by the stimulus.
module tb_ctrl_pipe;
    localparam int W = 14;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [W-1:0] exp_q[$];

    ctrl_pipe_if #(.W(W), .N(N)) bus ();

    ctrl_pipe #(.W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] c);
        bus.in_valid = v;
        bus.in_ctrl  = c;
    endtask

    // Scoreboard monitor: a transfer happens at the next edge whenever
    // out_valid and out_ready are both high at the negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    check("sb_out_ctrl", 64'(bus.out_ctrl), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = '0;
        bus.stall_req = '0;
        bus.flush_req = '0;
        bus.out_ready = 1'b1;
`ifdef CTRL_PIPE_PERF_EN
        bus.perf_clr  = 1'b0;
`endif
        #2;
        check("rst_stage_valid", 64'(bus.stage_valid), 64'd0);
        check("rst_stage_ctrl", 64'(bus.stage_ctrl), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_rst_held", 64'(bus.held), 64'd0);

        // Stream 1..5 back-to-back: first bundle visible after the 3rd edge.
        for (int i = 1; i <= 5; i++) exp_q.push_back(W'(i));
        for (int j = 1; j <= 8; j++) begin
            if (j <= 5) drive(1'b1, W'(j));
            else        drive(1'b0, '0);
            tick();
            check("stream_out_valid", 64'(bus.out_valid), 64'((j >= 3) && (j <= 7)));
            check("stream_out_ctrl", 64'(bus.out_ctrl), ((j >= 3) && (j <= 7)) ? 64'(j - 2) : 64'd0);
        end

        // Stall stage 1 for two cycles on a full pipe.
        for (int i = 'h11; i <= 'h16; i++) exp_q.push_back(W'(i));
        drive(1'b1, 14'h11); tick();
        drive(1'b1, 14'h12); tick();
        drive(1'b1, 14'h13); tick();
        drive(1'b1, 14'h14);
        bus.stall_req = 3'b010;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("stall_held", 64'(bus.held), 64'b011);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
            check("stall_stage_valid", 64'(bus.stage_valid), 64'b011);
            check("stall_out_ctrl", 64'(bus.out_ctrl), 64'd0);
            check("stall_stage1", 64'(bus.stage_ctrl[W +: W]), 64'h12);
        end
        bus.stall_req = '0;
        tick();
        drive(1'b1, 14'h15); tick();
        drive(1'b1, 14'h16); tick();
        drive(1'b0, '0);
        tick(); tick(); tick();

        // Bubble in stage 1 while the output is blocked.
        exp_q.push_back(14'h21);
        exp_q.push_back(14'h22);
        exp_q.push_back(14'h23);
        drive(1'b1, 14'h21); tick();
        drive(1'b0, '0);     tick();
        drive(1'b1, 14'h22); tick();
        bus.out_ready = 1'b0;
        drive(1'b1, 14'h23);
        #1;
        check("squeeze_held", 64'(bus.held), 64'b100);
        check("squeeze_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check("squeeze_held_full", 64'(bus.held), 64'b111);
        check("squeeze_stage_ctrl", 64'(bus.stage_ctrl), {22'd0, 14'h21, 14'h22, 14'h23});
        drive(1'b0, '0);
        bus.out_ready = 1'b1;
        tick(); tick(); tick();

        // Flush stage 1 on a full pipe: 0x00A is lost, 0x00B moves on.
        exp_q.push_back(14'h00C);
        exp_q.push_back(14'h00B);
        drive(1'b1, 14'h00C); tick();
        drive(1'b1, 14'h00B); tick();
        drive(1'b1, 14'h00A); tick();
        drive(1'b0, '0);
        bus.flush_req = 3'b010;
        tick();
        bus.flush_req = '0;
        check("flush_stage_valid", 64'(bus.stage_valid), 64'b100);
        check("flush_out_ctrl", 64'(bus.out_ctrl), 64'h00B);
        check("flush_stage1_ctrl", 64'(bus.stage_ctrl[W +: W]), 64'd0);
        drive(1'b1, 14'h00D); tick();
        drive(1'b0, '0);      tick();
        bus.flush_req = 3'b010;
        bus.stall_req = 3'b010;
        #1;
        check("flush_no_held_effect", 64'(bus.held), 64'b010);
        tick();
        bus.flush_req = '0;
        bus.stall_req = '0;
        check("flush_stall_stage_valid", 64'(bus.stage_valid), 64'b000);
        tick(); tick(); tick();

        // Asynchronous reset in the middle of a stream.
        drive(1'b1, 14'h31); tick();
        drive(1'b1, 14'h32); tick();
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.stage_valid), 64'd0);
        check("async_rst_ctrl", 64'(bus.stage_ctrl), 64'd0);
`ifdef CTRL_PIPE_PERF_EN
        check("async_rst_stall_cnt", 64'(bus.stall_cycles), 64'd0);
        check("async_rst_bubble_cnt", 64'(bus.bubble_cycles), 64'd0);
`endif
        drive(1'b0, '0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef CTRL_PIPE_PERF_EN
        check("idle_bubble_cnt", 64'(bus.bubble_cycles), 64'd5);
        check("idle_stall_cnt", 64'(bus.stall_cycles), 64'd0);
`endif

        check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter W, 14, width of one control bundle.
REQ-002 SHALL have parameter N, 3, number of pipeline stage registers (N>=2); stage 0 nearest input.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  upstream bundle present.
REQ-006 SHALL have port in_ctrl  in  W  upstream control bundle.
REQ-007 SHALL have port in_ready  out  1  stage 0 accepts this cycle (= ~held[0]).
REQ-008 SHALL have port stall_req  in  N  per-stage hold request.
REQ-009 SHALL have port flush_req  in  N  per-stage kill request.
REQ-010 SHALL have port out_ready  in  1  downstream consumer accepts stage N-1.
REQ-011 SHALL have port stage_valid  out  N  valid bit of each stage register.
REQ-012 SHALL have port stage_ctrl  out  N*W  bundle of stage k at bits [k*W +: W].
REQ-013 SHALL have port held  out  N  effective hold per stage.
REQ-014 SHALL have ports out_valid / out_ctrl  out  1 / W  copies of stage N-1 valid/bundle.
REQ-015 SHALL have ports perf_clr in 1, stall_cycles out 32, bubble_cycles out 32 (present only with CTRL_PIPE_PERF_EN).

Function
REQ-016 SHALL compute held combinationally: held[N-1] = stall_req[N-1] | (stage_valid[N-1] & ~out_ready); held[k] = stall_req[k] | (stage_valid[k] & held[k+1]) for k<N-1.
REQ-017 SHALL squeeze bubbles: an empty stage not stall-requested is never held by downstream holds.
REQ-018 SHALL, for a held stage without flush, keep its valid and bundle unchanged.
REQ-019 SHALL, for non-held stage k>0, load stage k-1 contents when stage k-1 is not held, else load a bubble.
REQ-020 SHALL, for non-held stage 0, load {in_valid, in_ctrl}; in_ctrl is accepted only when in_valid=1 and in_ready=1.
REQ-021 SHALL force bundle to 0 whenever the stored valid is 0 (bubbles carry all-zero control).
REQ-022 SHALL, on flush_req[k]=1, make stage k a bubble next cycle, overriding hold and load; contents that would have entered stage k are discarded.
REQ-023 SHALL NOT let flush_req affect held[] in the same cycle.
REQ-024 SHALL give latency N cycles: bundle accepted at edge t is at out_ctrl after edge t+N-1 when unstalled (N=3: visible 3 cycles after presentation).
REQ-025 SHALL treat stall and flush of different stages independently in the same cycle.

Reset
REQ-026 SHALL on rst=0 immediately clear all stage_valid and stage_ctrl to 0 and counters to 0, irrespective of clk.
REQ-027 SHALL after release present in_ready=1 (absent stall_req[0]), out_valid=0, held=0 (absent stall_req).

Configuration
REQ-028 SHALL, with CTRL_PIPE_PERF_EN defined, increment stall_cycles each cycle in_valid & ~in_ready and bubble_cycles each cycle out_valid=0, both saturating at 0xFFFFFFFF, synchronously cleared by perf_clr (clear wins over increment).
REQ-029 SHALL, without CTRL_PIPE_PERF_EN, omit perf_clr, stall_cycles, bubble_cycles and their registers entirely; pipeline behaviour identical.

Verification
REQ-030 Stream N=3: in_ctrl 0x0001..0x0005 on consecutive cycles, no stall -> out_ctrl 0x0001 three cycles after first presentation, then 0x0002..0x0005 back-to-back, out_valid=1 throughout.
REQ-031 Full pipe, stall_req[1]=1 for 2 cycles -> stages 0,1 hold, in_ready=0, stage 2 bubble (valid 0, ctrl 0x0000) for 2 cycles, stream resumes without loss or duplication.
REQ-032 Bubble in stage 1, out_ready=0 with stage 2 valid -> held=3'b100, stage 0 moves into stage 1, in_ready stays 1; next cycle held=3'b111.
REQ-033 Stages 0/1/2 hold 0x00A/0x00B/0x00C, flush_req[1]=1 -> next cycle stage 1 bubble, 0x00A discarded, out_ctrl=0x00B; flush_req[1] with stall_req[1] simultaneously -> stage 1 still bubble.
REQ-034 Assert rst=0 mid-stream between clock edges -> stage_valid=0, stage_ctrl=0 at once; with CTRL_PIPE_PERF_EN counters 0, and 5 idle cycles after release give bubble_cycles=5.
